// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin arbiter that shares one snooping bus between
// NUM_CORES L1 controllers. One transaction is outstanding at a time. The grant
// is held until the transaction completes. The memory response is steered back
// to the core that was granted.
// req_type / bus_type encoding: 2'd0 BUS_RD, 2'd1 BUS_RDX, 2'd2 BUS_UPGR, 2'd3 BUS_WB.
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 26,
  parameter int LINE_W    = 512,
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  output logic [NUM_CORES-1:0]        req_ready,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*2-1:0]      req_type,
  input  logic [NUM_CORES*LINE_W-1:0] req_data,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [LINE_W-1:0]           resp_data,
  output logic                        resp_shared,
  output logic                        bus_valid,
  input  logic                        bus_ready,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [1:0]                  bus_type,
  output logic [LINE_W-1:0]           bus_data,
  output logic [IDX_W-1:0]            bus_src,
  input  logic                        mem_resp_valid,
  input  logic [LINE_W-1:0]           mem_resp_data,
  input  logic                        mem_resp_shared
);

  localparam logic [1:0] BUS_RD  = 2'd0;
  localparam logic [1:0] BUS_RDX = 2'd1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_next;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic             sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]       sel_type;
  logic [LINE_W-1:0] sel_data;

  // Successor of a core index, wrapping from NUM_CORES-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_CORES - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  // Response payload is broadcast; only resp_valid is steered.
  assign resp_data   = mem_resp_data;
  assign resp_shared = mem_resp_shared;

  // Round-robin search: first pending core at or after rr_ptr, modulo NUM_CORES.
  always_comb begin
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CORES;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end else begin
        arb_found = arb_found;
      end
    end
  end

  // Select the granted core's request fields.
  always_comb begin
    sel_valid = req_valid[grant];
    sel_addr  = req_addr[int'(grant)*ADDR_W +: ADDR_W];
    sel_type  = req_type[int'(grant)*2 +: 2];
    sel_data  = req_data[int'(grant)*LINE_W +: LINE_W];
  end

  // Next-state logic and the per-state outputs (ready/valid are combinational).
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    req_ready   = '0;
    resp_valid  = '0;
    bus_valid   = 1'b0;
    bus_addr    = '0;
    bus_type    = 2'b00;
    bus_data    = '0;
    bus_src     = '0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_next = arb_idx;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        bus_valid        = sel_valid;
        bus_addr         = sel_addr;
        bus_type         = sel_type;
        bus_data         = sel_data;
        bus_src          = grant;
        req_ready[grant] = bus_ready;
        if (!sel_valid) begin
          // Requester withdrew before the handshake: abandon, pointer unchanged.
          state_next = IDLE;
        end else if (bus_ready) begin
          if (sel_type == BUS_RD || sel_type == BUS_RDX) begin
            state_next = WAIT_RESP;
          end else begin
            // UPGR and WB carry no data response; done at handshake.
            rr_ptr_next = next_idx(grant);
            state_next  = IDLE;
          end
        end else begin
          state_next = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          resp_valid[grant] = 1'b1;
          rr_ptr_next       = next_idx(grant);
          state_next        = IDLE;
        end else begin
          state_next = WAIT_RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule
